// File: rtl/pcileech_com_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_com_pkg
//
// Shared definitions for the clk_com communication core.
//   COM_RESYNC_DW   : the 32-bit resync marker that the receive-side 32->64
//                     packer hunts for. Two back-to-back copies realign it.
//   com_tx_state_t  : state encoding of the 64->32 transmit serializer.
// ---------------------------------------------------------------------------
package pcileech_com_pkg;

    localparam logic [31:0] COM_RESYNC_DW = 32'h66665555;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        RS1  = 3'd3,
        RS2  = 3'd4
    } com_tx_state_t;

endpackage

// File: rtl/pcileech_com_tx64to32.sv
// ---------------------------------------------------------------------------
// pcileech_com_tx64to32
//
// Serializes 64-bit words into the 32-bit stream that the com receive path
// packs back into 64-bit words. The high DW goes first, then the low DW.
// A resync pair (COM_RESYNC_DW twice) is inserted between words on request
// or after RESYNC_IDLE idle cycles, keeping the receiver's packer aligned.
// Data that would itself look like a resync pattern is sent unchanged but
// flagged on 'collision'.
//
// Ports
//   clk, rst_n    : clk_com clock, asynchronous active-low reset
//   din[63:0]     : word to send, [63:32] goes out first
//   din_valid     : din holds a word
//   din_ready     : word accepted when din_valid & din_ready
//   resync_req    : one-cycle request for a resync pair at the next boundary
//   dout[31:0]    : serialized DW
//   dout_valid    : dout holds a DW
//   dout_ready    : downstream accepts the DW
//   collision     : one-cycle pulse, last sent data formed a resync pattern
//   tx_words      : number of 64-bit words fully sent (wraps)
//
// RESYNC_IDLE : idle cycles before an automatic resync pair, 0 disables it.
// ---------------------------------------------------------------------------
module pcileech_com_tx64to32
    import pcileech_com_pkg::*;
#(
    parameter int RESYNC_IDLE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        resync_req,
    output logic [31:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        collision,
    output logic [31:0] tx_words
);

    localparam int IDLE_W = ($clog2(RESYNC_IDLE + 1) > 1) ? $clog2(RESYNC_IDLE + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(RESYNC_IDLE);

    com_tx_state_t     state;
    logic [63:0]       hold;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_inc;
    logic              resync_pending;
    logic              last_lo_match;
    logic              rst_done;
    logic              dout_xfer;
    logic              din_accept;

    // A new word can enter from IDLE, or back-to-back while the current low
    // DW leaves. A pending resync blocks intake so the pair lands on a word
    // boundary. rst_done keeps din_ready low until the first edge after reset.
    assign din_ready    = rst_done & ~resync_pending &
                          ((state == IDLE) | ((state == LO) & dout_ready));
    assign din_accept   = din_valid & din_ready;
    assign dout_xfer    = dout_valid & dout_ready;
    assign idle_cnt_inc = idle_cnt + IDLE_W'(1);

    // Single FSM block. dout/dout_valid are loaded together with the state
    // they belong to, so the outputs come straight from flops and hold
    // naturally under backpressure. The idle counter stops at IDLE_LIMIT
    // after firing and only restarts from a din accept, so the automatic
    // pair fires once per idle period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hold           <= '0;
            dout           <= '0;
            dout_valid     <= 1'b0;
            collision      <= 1'b0;
            tx_words       <= '0;
            resync_pending <= 1'b0;
            idle_cnt       <= '0;
            last_lo_match  <= 1'b0;
            rst_done       <= 1'b0;
        end else begin
            rst_done  <= 1'b1;
            collision <= 1'b0;

            if (resync_req) begin
                resync_pending <= 1'b1;
            end

            if (din_accept) begin
                idle_cnt <= '0;
            end else if ((RESYNC_IDLE != 0) && (state == IDLE) && !resync_pending &&
                         (idle_cnt != IDLE_LIMIT)) begin
                idle_cnt <= idle_cnt_inc;
                if (idle_cnt_inc == IDLE_LIMIT) begin
                    resync_pending <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (resync_pending) begin
                        state      <= RS1;
                        dout       <= COM_RESYNC_DW;
                        dout_valid <= 1'b1;
                    end else if (din_accept) begin
                        hold       <= din;
                        dout       <= din[63:32];
                        dout_valid <= 1'b1;
                        state      <= HI;
                    end
                end

                HI: begin
                    if (dout_xfer) begin
                        state         <= LO;
                        dout          <= hold[31:0];
                        // Previous low DW plus this high DW form the pair.
                        collision     <= last_lo_match && (hold[63:32] == COM_RESYNC_DW);
                        last_lo_match <= 1'b0;
                    end
                end

                LO: begin
                    if (dout_xfer) begin
                        tx_words      <= tx_words + 32'd1;
                        last_lo_match <= (hold[31:0] == COM_RESYNC_DW);
                        collision     <= (hold == {COM_RESYNC_DW, COM_RESYNC_DW});
                        if (din_accept) begin
                            hold  <= din;
                            dout  <= din[63:32];
                            state <= HI;
                        end else if (resync_pending) begin
                            dout  <= COM_RESYNC_DW;
                            state <= RS1;
                        end else begin
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end

                RS1: begin
                    if (dout_xfer) begin
                        state         <= RS2;
                        last_lo_match <= 1'b0;
                    end
                end

                RS2: begin
                    if (dout_xfer) begin
                        state          <= IDLE;
                        dout           <= '0;
                        dout_valid     <= 1'b0;
                        last_lo_match  <= 1'b0;
                        // A request landing on the closing DW queues another pair.
                        resync_pending <= resync_req;
                    end
                end

                default: begin
                    state      <= IDLE;
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_com_tx64to32.sv
// ---------------------------------------------------------------------------
// tb_pcileech_com_tx64to32
//
// Directed bench for the 64->32 com serializer. The main instance has auto
// resync disabled so directed sequences are exact; a second instance with
// RESYNC_IDLE=8 exercises the idle-gap resync.
// ---------------------------------------------------------------------------
module tb_pcileech_com_tx64to32;

    localparam logic [31:0] RS_DW = 32'h66665555;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        resync_req;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        collision;
    logic [31:0] tx_words;

    logic        rst2_n;
    logic [63:0] din2;
    logic        din2_valid;
    logic        din2_ready;
    logic        resync2_req;
    logic [31:0] dout2;
    logic        dout2_valid;
    logic        dout2_ready;
    logic        collision2;
    logic [31:0] tx_words2;

    int vectors = 0;
    int miscompares = 0;

    // Everything below is written only by the monitors; tests take snapshots.
    logic [31:0] rx_q[$];
    int          rx_cyc[$];
    logic [31:0] rx2_q[$];
    int          cyc = 0;
    int          coll_cnt = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;

    pcileech_com_tx64to32 #(.RESYNC_IDLE(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .resync_req (resync_req),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .collision  (collision),
        .tx_words   (tx_words)
    );

    pcileech_com_tx64to32 #(.RESYNC_IDLE(8)) dut_idle (
        .clk        (clk),
        .rst_n      (rst2_n),
        .din        (din2),
        .din_valid  (din2_valid),
        .din_ready  (din2_ready),
        .resync_req (resync2_req),
        .dout       (dout2),
        .dout_valid (dout2_valid),
        .dout_ready (dout2_ready),
        .collision  (collision2),
        .tx_words   (tx_words2)
    );

    // 100 MHz clk_com
    always #5 clk = ~clk;

    // Cycle stamp used to prove DWs leave on consecutive cycles.
    always @(posedge clk) cyc++;

    // Receive-side monitor sampled on the falling edge, where the values that
    // the next rising edge transfers are stable. Also checks that a stalled
    // DW is held unchanged into the following cycle.
    always @(negedge clk) begin
        if (dout_valid && dout_ready) begin
            rx_q.push_back(dout);
            rx_cyc.push_back(cyc);
        end
        if (collision) coll_cnt++;
        if (prev_stall && (!dout_valid || dout != prev_dout)) stall_err++;
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        if (dout2_valid && dout2_ready) rx2_q.push_back(dout2);
    end

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Offers one word on din and returns one tick after the accepting edge.
    task automatic applyStimulus(input logic [63:0] word);
        int waited = 0;
        din       = word;
        din_valid = 1'b1;
        @(negedge clk);
        while (!din_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!din_ready) checkOutput("accept_timeout", 64'(din_ready), 64'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    // Reset pulse on the main instance with the downstream always ready.
    task automatic resetDut();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        resync_req = 1'b0;
        dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Test sequence
    initial begin
        int base;
        int cbase;
        int bad;
        int waited;
        bit stop_rand;
        logic [63:0] exp_q[$];
        logic [63:0] w;

        rst_n = 1'b0; din = '0; din_valid = 1'b0; resync_req = 1'b0; dout_ready = 1'b1;
        rst2_n = 1'b0; din2 = '0; din2_valid = 1'b0; resync2_req = 1'b0; dout2_ready = 1'b1;

        // Reset state, and din_ready only after the first edge past release
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dout", 64'(dout), 64'd0);
        checkOutput("rst_dout_valid", 64'(dout_valid), 64'd0);
        checkOutput("rst_din_ready", 64'(din_ready), 64'd0);
        checkOutput("rst_collision", 64'(collision), 64'd0);
        checkOutput("rst_tx_words", 64'(tx_words), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 64'(din_ready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", 64'(din_ready), 64'd1);

        // Two back-to-back words, no bubble
        resetDut();
        base = rx_q.size();
        applyStimulus(64'h11112222_33334444);
        applyStimulus(64'hAAAABBBB_CCCCDDDD);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("b2b_count", 64'(rx_q.size() - base), 64'd4);
        if (rx_q.size() - base >= 4) begin
            checkOutput("b2b_dw0", 64'(rx_q[base]),     64'h11112222);
            checkOutput("b2b_dw1", 64'(rx_q[base + 1]), 64'h33334444);
            checkOutput("b2b_dw2", 64'(rx_q[base + 2]), 64'hAAAABBBB);
            checkOutput("b2b_dw3", 64'(rx_q[base + 3]), 64'hCCCCDDDD);
            checkOutput("b2b_span", 64'(rx_cyc[base + 3] - rx_cyc[base]), 64'd3);
        end
        checkOutput("b2b_tx_words", 64'(tx_words), 64'd2);

        // Resync request during HI: pair follows the word, next din held off
        resetDut();
        base = rx_q.size();
        applyStimulus(64'h01234567_89ABCDEF);
        resync_req = 1'b1;
        @(posedge clk);
        #1;
        resync_req = 1'b0;
        @(negedge clk);
        checkOutput("rs_ready_held_lo", 64'(din_ready), 64'd0);
        @(negedge clk);
        checkOutput("rs_ready_held_rs1", 64'(din_ready), 64'd0);
        applyStimulus(64'h5555AAAA_12345678);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rs_count", 64'(rx_q.size() - base), 64'd6);
        if (rx_q.size() - base >= 6) begin
            checkOutput("rs_dw0", 64'(rx_q[base]),     64'h01234567);
            checkOutput("rs_dw1", 64'(rx_q[base + 1]), 64'h89ABCDEF);
            checkOutput("rs_dw2", 64'(rx_q[base + 2]), 64'(RS_DW));
            checkOutput("rs_dw3", 64'(rx_q[base + 3]), 64'(RS_DW));
            checkOutput("rs_dw4", 64'(rx_q[base + 4]), 64'h5555AAAA);
            checkOutput("rs_dw5", 64'(rx_q[base + 5]), 64'h12345678);
        end
        checkOutput("rs_tx_words", 64'(tx_words), 64'd2);

        // Auto resync after 8 idle cycles, once, rearmed by a data word
        @(posedge clk);
        #1;
        rst2_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("idle_none_early", 64'(rx2_q.size()), 64'd0);
        repeat (25) @(posedge clk);
        #1;
        checkOutput("idle_pair_count", 64'(rx2_q.size()), 64'd2);
        if (rx2_q.size() >= 2) begin
            checkOutput("idle_pair_dw0", 64'(rx2_q[0]), 64'(RS_DW));
            checkOutput("idle_pair_dw1", 64'(rx2_q[1]), 64'(RS_DW));
        end
        repeat (40) @(posedge clk);
        #1;
        checkOutput("idle_no_repeat", 64'(rx2_q.size()), 64'd2);
        din2       = 64'hCAFEF00D_12345678;
        din2_valid = 1'b1;
        waited     = 0;
        @(negedge clk);
        while (!din2_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!din2_ready) checkOutput("idle_accept_timeout", 64'(din2_ready), 64'd1);
        @(posedge clk);
        #1;
        din2_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("rearm_count", 64'(rx2_q.size()), 64'd6);
        if (rx2_q.size() >= 6) begin
            checkOutput("rearm_dw2", 64'(rx2_q[2]), 64'hCAFEF00D);
            checkOutput("rearm_dw3", 64'(rx2_q[3]), 64'h12345678);
            checkOutput("rearm_dw4", 64'(rx2_q[4]), 64'(RS_DW));
            checkOutput("rearm_dw5", 64'(rx2_q[5]), 64'(RS_DW));
        end
        checkOutput("rearm_tx_words", 64'(tx_words2), 64'd1);

        // 1000 random words with random 50% backpressure
        resetDut();
        base      = rx_q.size();
        cbase     = stall_err;
        stop_rand = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    w = {$urandom, $urandom};
                    exp_q.push_back(w);
                    applyStimulus(w);
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk);
                    #1;
                    dout_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        dout_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rand_count", 64'(rx_q.size() - base), 64'd2000);
        bad = 0;
        if (rx_q.size() - base >= 2000) begin
            for (int i = 0; i < 1000; i++) begin
                if ({rx_q[base + 2 * i], rx_q[base + 2 * i + 1]} !== exp_q[i]) bad++;
            end
        end
        checkOutput("rand_words_bad", 64'(bad), 64'd0);
        checkOutput("rand_stall_stable", 64'(stall_err - cbase), 64'd0);
        checkOutput("rand_tx_words", 64'(tx_words), 64'd1000);

        // Collision flags: cross-word, in-word, and clean data
        resetDut();
        cbase = coll_cnt;
        applyStimulus(64'h00000000_66665555);
        applyStimulus(64'h66665555_00000000);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("coll_cross", 64'(coll_cnt - cbase), 64'd1);
        cbase = coll_cnt;
        base  = rx_q.size();
        applyStimulus(64'h66665555_66665555);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("coll_inword", 64'(coll_cnt - cbase), 64'd1);
        if (rx_q.size() - base >= 2) begin
            checkOutput("coll_inword_data", {rx_q[base], rx_q[base + 1]}, 64'h66665555_66665555);
        end
        cbase = coll_cnt;
        applyStimulus(64'h12345678_66665555);
        applyStimulus(64'h12345678_9ABCDEF0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("coll_clean", 64'(coll_cnt - cbase), 64'd0);

        // Asynchronous reset during LO of a word
        resetDut();
        applyStimulus(64'hDEADBEEF_0BADF00D);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dout_valid", 64'(dout_valid), 64'd0);
        checkOutput("midrst_dout", 64'(dout), 64'd0);
        checkOutput("midrst_din_ready", 64'(din_ready), 64'd0);
        checkOutput("midrst_tx_words", 64'(tx_words), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = rx_q.size();
        applyStimulus(64'h13579BDF_2468ACE0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("postrst_count", 64'(rx_q.size() - base), 64'd2);
        if (rx_q.size() - base >= 2) begin
            checkOutput("postrst_word", {rx_q[base], rx_q[base + 1]}, 64'h13579BDF_2468ACE0);
        end
        checkOutput("postrst_tx_words", 64'(tx_words), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
